// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared sizes, entry layout and FSM states for the reorder buffer.
package reorder_buffer_pkg;
    localparam int ROB_WIDTH_BIT = 3;
    localparam int ROB_SIZE = 1 << ROB_WIDTH_BIT;
    localparam int REG_ID_W = 5;
    localparam int XLEN = 32;
    typedef logic [ROB_WIDTH_BIT-1:0] rob_tag_t;
    typedef logic [ROB_WIDTH_BIT:0] rob_cnt_t;
    typedef enum logic {RUN, FLUSH} rob_state_e;
    typedef struct packed {
        logic                busy;
        logic                ready;
        logic [REG_ID_W-1:0] rd;
        logic                is_br;
        logic                pred_jmp;
        logic                jmp;
        logic [XLEN-1:0]     val;
        logic [XLEN-1:0]     target;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_lookup_port.sv
// reorder_buffer_lookup_port: operand lookup of one ROB tag with CDB bypass.
module reorder_buffer_lookup_port
    import reorder_buffer_pkg::*;
(
    input  rob_tag_t        id_i,
    input  logic            busy_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] val_i,
    input  logic            cdb_valid_i,
    input  rob_tag_t        cdb_rob_id_i,
    input  logic [XLEN-1:0] cdb_val_i,
    output logic            ready_o,
    output logic [XLEN-1:0] val_o
);
    logic hit;
    assign hit     = cdb_valid_i && (cdb_rob_id_i == id_i);
    assign ready_o = busy_i && (ready_i || hit);
    assign val_o   = hit ? cdb_val_i : val_i;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with rename, CDB writeback, operand lookup,
// in-order commit and a two-step flush on branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  logic [REG_ID_W-1:0] issue_rd,
    input  logic                issue_is_br,
    input  logic                issue_pred_jmp,
    input  logic                issue_ready,
    input  logic [XLEN-1:0]     issue_val,
    output logic                rob_full,
    output logic [REG_ID_W-1:0] new_reg_id,
    output rob_tag_t            new_ROB_id,
    input  logic                cdb_valid,
    input  rob_tag_t            cdb_rob_id,
    input  logic [XLEN-1:0]     cdb_val,
    input  logic                cdb_jmp,
    input  logic [XLEN-1:0]     cdb_target,
    input  rob_tag_t            rs1_id,
    input  rob_tag_t            rs2_id,
    output logic                rs1_ready,
    output logic                rs2_ready,
    output logic [XLEN-1:0]     rs1_val,
    output logic [XLEN-1:0]     rs2_val,
    output logic [REG_ID_W-1:0] write_reg_id,
    output rob_tag_t            write_ROB_id,
    output logic [XLEN-1:0]     write_val,
    output logic                clear_flag,
    output logic [XLEN-1:0]     clear_pc,
    output rob_tag_t            head_id
);
    rob_entry_t          entries_q [ROB_SIZE];
    rob_entry_t          entries_d [ROB_SIZE];
    rob_tag_t            head_q, head_d, tail_q, tail_d, wr_tag_q, wr_tag_d;
    rob_cnt_t            count_q, count_d;
    rob_state_e          state_q, state_d;
    logic [REG_ID_W-1:0] wr_rd_q, wr_rd_d;
    logic [XLEN-1:0]     wr_val_q, wr_val_d, clr_pc_q, clr_pc_d, flush_pc_q, flush_pc_d;
    logic                clr_q, clr_d;
    rob_entry_t          head_e;
    logic                issue_acc, commit, mispredict, cdb_run;

    assign head_e     = entries_q[head_q];
    assign rob_full   = (count_q == rob_cnt_t'(ROB_SIZE)) || (state_q != RUN);
    assign issue_acc  = issue_valid && !rob_full && rdy_in;
    assign commit     = rdy_in && (state_q == RUN) && head_e.busy && head_e.ready;
    assign mispredict = commit && head_e.is_br && (head_e.jmp != head_e.pred_jmp);
    assign cdb_run    = cdb_valid && (state_q == RUN);
    assign new_reg_id = issue_acc ? issue_rd : '0;
    assign new_ROB_id = tail_q;
    assign head_id    = head_q;
    assign write_reg_id = wr_rd_q;
    assign write_ROB_id = wr_tag_q;
    assign write_val    = wr_val_q;
    assign clear_flag   = clr_q;
    assign clear_pc     = clr_pc_q;

    reorder_buffer_lookup_port u_rs1 (
        .id_i(rs1_id), .busy_i(entries_q[rs1_id].busy), .ready_i(entries_q[rs1_id].ready),
        .val_i(entries_q[rs1_id].val), .cdb_valid_i(cdb_run), .cdb_rob_id_i(cdb_rob_id),
        .cdb_val_i(cdb_val), .ready_o(rs1_ready), .val_o(rs1_val)
    );
    reorder_buffer_lookup_port u_rs2 (
        .id_i(rs2_id), .busy_i(entries_q[rs2_id].busy), .ready_i(entries_q[rs2_id].ready),
        .val_i(entries_q[rs2_id].val), .cdb_valid_i(cdb_run), .cdb_rob_id_i(cdb_rob_id),
        .cdb_val_i(cdb_val), .ready_o(rs2_ready), .val_o(rs2_val)
    );

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        state_d    = state_q;
        flush_pc_d = flush_pc_q;
        wr_rd_d    = wr_rd_q;
        wr_tag_d   = wr_tag_q;
        wr_val_d   = wr_val_q;
        clr_d      = clr_q;
        clr_pc_d   = clr_pc_q;
        if (rdy_in) begin
            wr_rd_d = '0;
            clr_d   = 1'b0;
            if (state_q == FLUSH) begin
                for (int i = 0; i < ROB_SIZE; i++) entries_d[i].busy = 1'b0;
                head_d   = '0;
                tail_d   = '0;
                count_d  = '0;
                state_d  = RUN;
                clr_d    = 1'b1;
                clr_pc_d = flush_pc_q;
            end else begin
                if (cdb_valid && entries_q[cdb_rob_id].busy) begin
                    entries_d[cdb_rob_id].ready  = 1'b1;
                    entries_d[cdb_rob_id].val    = cdb_val;
                    entries_d[cdb_rob_id].jmp    = cdb_jmp;
                    entries_d[cdb_rob_id].target = cdb_target;
                end
                if (commit) begin
                    entries_d[head_q].busy = 1'b0;
                    head_d   = head_q + 1'b1;
                    wr_rd_d  = head_e.rd;
                    wr_tag_d = head_q;
                    wr_val_d = head_e.val;
                end
                if (mispredict) begin
                    state_d    = FLUSH;
                    flush_pc_d = head_e.target;
                end
                if (issue_acc) begin
                    entries_d[tail_q] = '{busy: 1'b1, ready: issue_ready, rd: issue_rd,
                                          is_br: issue_is_br, pred_jmp: issue_pred_jmp,
                                          jmp: 1'b0, val: issue_val, target: '0};
                    tail_d = tail_q + 1'b1;
                end
                // Count, not pointer equality, distinguishes empty from full on wrap.
                count_d = count_q + rob_cnt_t'(issue_acc) - rob_cnt_t'(commit);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            entries_q  <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= RUN;
            flush_pc_q <= '0;
            wr_rd_q    <= '0;
            wr_tag_q   <= '0;
            wr_val_q   <= '0;
            clr_q      <= 1'b0;
            clr_pc_q   <= '0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            flush_pc_q <= flush_pc_d;
            wr_rd_q    <= wr_rd_d;
            wr_tag_q   <= wr_tag_d;
            wr_val_q   <= wr_val_d;
            clr_q      <= clr_d;
            clr_pc_q   <= clr_pc_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized stimulus against a queue-based program-order model of the ROB.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic            clk_in = 0, rst_in = 0, rdy_in = 1;
    logic            issue_valid = 0, issue_is_br = 0, issue_pred_jmp = 0, issue_ready = 0;
    logic [4:0]      issue_rd = 0;
    logic [31:0]     issue_val = 0;
    logic            rob_full;
    logic [4:0]      new_reg_id;
    rob_tag_t        new_ROB_id;
    logic            cdb_valid = 0, cdb_jmp = 0;
    rob_tag_t        cdb_rob_id = 0, rs1_id = 0, rs2_id = 0;
    logic [31:0]     cdb_val = 0, cdb_target = 0;
    logic            rs1_ready, rs2_ready;
    logic [31:0]     rs1_val, rs2_val;
    logic [4:0]      write_reg_id;
    rob_tag_t        write_ROB_id;
    logic [31:0]     write_val;
    logic            clear_flag;
    logic [31:0]     clear_pc;
    rob_tag_t        head_id;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .issue_pred_jmp(issue_pred_jmp), .issue_ready(issue_ready), .issue_val(issue_val),
        .rob_full(rob_full), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_jmp(cdb_jmp), .cdb_target(cdb_target),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
        .clear_flag(clear_flag), .clear_pc(clear_pc), .head_id(head_id)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        is_br, pred, ready, jmp;
        logic [31:0] val, target;
    } m_ent_t;

    m_ent_t      q[$];
    int          m_head;
    bit          m_flush, e_commit, e_clr;
    logic [31:0] m_flush_pc, e_wr_val, e_clr_pc;
    logic [4:0]  e_wr_rd;
    int          e_wr_tag;

    function automatic int m_tail();
        return (m_head + q.size()) % ROB_SIZE;
    endfunction

    function automatic int m_find(input int tag);
        int idx;
        idx = (tag - m_head + ROB_SIZE) % ROB_SIZE;
        return (idx < q.size()) ? idx : -1;
    endfunction

    task automatic m_reset();
        q.delete();
        m_head = 0; m_flush = 0; m_flush_pc = 0;
        e_commit = 0; e_clr = 0; e_wr_rd = 0; e_wr_tag = 0; e_wr_val = 0; e_clr_pc = 0;
    endtask

    task automatic check_regs();
        check("write_reg_id", 32'(write_reg_id), 32'(e_wr_rd));
        if (e_commit) begin
            check("write_ROB_id", 32'(write_ROB_id), 32'(e_wr_tag));
            check("write_val", write_val, e_wr_val);
        end
        check("clear_flag", 32'(clear_flag), 32'(e_clr));
        if (e_clr) check("clear_pc", clear_pc, e_clr_pc);
    endtask

    task automatic lookup(input string tag, input int id, input logic got_rdy, input logic [31:0] got_val);
        int idx;
        bit hit, er;
        idx = m_find(id);
        hit = cdb_valid && (32'(cdb_rob_id) == 32'(id));
        er  = (idx >= 0) && (q[idx].ready || hit);
        check({tag, "_ready"}, 32'(got_rdy), 32'(er));
        if (er) check({tag, "_val"}, got_val, hit ? cdb_val : q[idx].val);
    endtask

    task automatic check_comb();
        bit full, acc;
        full = (q.size() == ROB_SIZE) || m_flush;
        acc  = issue_valid && !full && rdy_in;
        check("rob_full", 32'(rob_full), 32'(full));
        check("new_reg_id", 32'(new_reg_id), acc ? 32'(issue_rd) : 32'd0);
        check("new_ROB_id", 32'(new_ROB_id), 32'(m_tail()));
        check("head_id", 32'(head_id), 32'(m_head));
        if (!m_flush) begin
            lookup("rs1", int'(rs1_id), rs1_ready, rs1_val);
            lookup("rs2", int'(rs2_id), rs2_ready, rs2_val);
        end
    endtask

    task automatic m_step();
        bit full, acc, commit;
        int idx;
        m_ent_t h, n;
        if (!rdy_in) return;
        if (m_flush) begin
            q.delete();
            m_head = 0; m_flush = 0;
            e_wr_rd = 0; e_commit = 0; e_clr = 1; e_clr_pc = m_flush_pc;
            return;
        end
        e_clr  = 0;
        full   = (q.size() == ROB_SIZE);
        acc    = issue_valid && !full;
        commit = (q.size() > 0) && q[0].ready;
        e_commit = commit;
        e_wr_rd  = 0;
        if (commit) begin
            h = q[0];
            e_wr_rd = h.rd; e_wr_tag = m_head; e_wr_val = h.val;
        end
        if (cdb_valid) begin
            idx = m_find(int'(cdb_rob_id));
            if (idx >= 0) begin
                q[idx].ready = 1; q[idx].val = cdb_val;
                q[idx].jmp = cdb_jmp; q[idx].target = cdb_target;
            end
        end
        if (commit) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % ROB_SIZE;
            if (h.is_br && (h.jmp != h.pred)) begin
                m_flush = 1;
                m_flush_pc = h.target;
            end
        end
        if (acc) begin
            n.rd = issue_rd; n.is_br = issue_is_br; n.pred = issue_pred_jmp;
            n.ready = issue_ready; n.jmp = 0; n.val = issue_val; n.target = 0;
            q.push_back(n);
        end
    endtask

    task automatic drive(input int p_iss, input int p_cdb);
        int pend[$];
        rdy_in         = ($urandom_range(0, 9) != 0);
        issue_valid    = ($urandom_range(0, 99) < p_iss);
        issue_rd       = 5'($urandom);
        issue_is_br    = ($urandom_range(0, 5) == 0);
        issue_pred_jmp = 1'($urandom);
        issue_ready    = !issue_is_br && ($urandom_range(0, 2) == 0);
        issue_val      = $urandom;
        for (int i = 0; i < q.size(); i++)
            if (!q[i].ready) pend.push_back((m_head + i) % ROB_SIZE);
        cdb_valid  = ($urandom_range(0, 99) < p_cdb);
        cdb_rob_id = (pend.size() > 0 && $urandom_range(0, 4) != 0)
                     ? rob_tag_t'(pend[$urandom_range(0, pend.size() - 1)]) : rob_tag_t'($urandom);
        cdb_val    = $urandom;
        cdb_jmp    = 1'($urandom);
        cdb_target = $urandom & 32'hFFFF_FFFC;
        rs1_id     = rob_tag_t'($urandom);
        rs2_id     = ($urandom_range(0, 1) == 0) ? cdb_rob_id : rob_tag_t'($urandom);
    endtask

    task automatic do_reset();
        rst_in = 0;
        #1;
        check("rst_rob_full", 32'(rob_full), 32'd0);
        check("rst_write_reg_id", 32'(write_reg_id), 32'd0);
        check("rst_clear_flag", 32'(clear_flag), 32'd0);
        check("rst_head_id", 32'(head_id), 32'd0);
        check("rst_new_ROB_id", 32'(new_ROB_id), 32'd0);
        issue_valid = 0; cdb_valid = 0; rdy_in = 1;
        m_reset();
        @(negedge clk_in);
        rst_in = 1;
    endtask

    initial begin
        int p_iss, p_cdb;
        m_reset();
        #1;
        check("init_rob_full", 32'(rob_full), 32'd0);
        check("init_write_reg_id", 32'(write_reg_id), 32'd0);
        check("init_clear_flag", 32'(clear_flag), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_in);
            #1;
            check_regs();
            if (i == 800) begin
                do_reset();
                continue;
            end
            case ((i / 100) % 3)
                0: begin p_iss = 90; p_cdb = 25; end
                1: begin p_iss = 40; p_cdb = 85; end
                default: begin p_iss = 65; p_cdb = 60; end
            endcase
            drive(p_iss, p_cdb);
            #2;
            check_comb();
            m_step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
